// File: rtl/nibble_serializer.sv
// Parallel-load to framed serial transmitter: start(0), WIDTH data bits LSB first, stop(1).
// Define NIBBLE_SERIALIZER_PARITY_EN to insert an even-parity bit between data and stop.
module nibble_serializer #(
   parameter int WIDTH        = 4,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] D,
   input  logic             LD,
   output logic             BUSY,
   output logic             TXD,
   output logic             DONE
);

`ifdef NIBBLE_SERIALIZER_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
   localparam logic [3:0] IDX_LAST  = 4'(WIDTH - 1);

   state_t           state, state_n;
   logic [WIDTH-1:0] sh, sh_n;
   logic [3:0]       idx, idx_n;
   logic [7:0]       baud, baud_n;
   logic             bit_last;
   logic             txd_n;
`ifdef NIBBLE_SERIALIZER_PARITY_EN
   logic             par;
`endif

   assign bit_last = (baud == BAUD_LAST);

   always_comb begin
      state_n = state;
      sh_n    = sh;
      idx_n   = idx;
      baud_n  = bit_last ? '0 : baud + 8'd1;
      case (state)
         S_IDLE: begin
            baud_n = '0;
            if (LD) begin
               sh_n    = D;
               state_n = S_START;
            end
         end
         S_START: begin
            if (bit_last) begin
               idx_n   = '0;
               state_n = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_last) begin
               sh_n = sh >> 1;
               if (idx == IDX_LAST) begin
`ifdef NIBBLE_SERIALIZER_PARITY_EN
                  state_n = S_PARITY;
`else
                  state_n = S_STOP;
`endif
               end else begin
                  idx_n = idx + 4'd1;
               end
            end
         end
`ifdef NIBBLE_SERIALIZER_PARITY_EN
         S_PARITY: begin
            if (bit_last) state_n = S_STOP;
         end
`endif
         S_STOP: begin
            if (bit_last) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Outputs are registered from the next-state values so they line up with the state itself.
   always_comb begin
      txd_n = 1'b1;
      case (state_n)
         S_START:  txd_n = 1'b0;
         S_DATA:   txd_n = sh_n[0];
`ifdef NIBBLE_SERIALIZER_PARITY_EN
         S_PARITY: txd_n = par;
`endif
         default:  txd_n = 1'b1;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state <= S_IDLE;
         sh    <= '0;
         idx   <= '0;
         baud  <= '0;
         TXD   <= 1'b1;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
`ifdef NIBBLE_SERIALIZER_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         state <= state_n;
         sh    <= sh_n;
         idx   <= idx_n;
         baud  <= baud_n;
         TXD   <= txd_n;
         BUSY  <= (state_n != S_IDLE);
         DONE  <= (state_n == S_STOP) && (baud_n == BAUD_LAST);
`ifdef NIBBLE_SERIALIZER_PARITY_EN
         if (state == S_IDLE && LD) par <= ^D;
`endif
      end
   end

endmodule

// File: tb/tb_nibble_serializer.sv
// Self-checking bench for nibble_serializer: frame-level reference model plus directed literal frames.
module tb_nibble_serializer;

   localparam int W   = 4;
   localparam int CPB = 4;
`ifdef NIBBLE_SERIALIZER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FL = (W + 2 + PAR) * CPB;

   logic         CLK = 1'b0;
   logic         RST = 1'b0;
   logic [W-1:0] D   = '0;
   logic         LD  = 1'b0;
   logic         BUSY, TXD, DONE;

   nibble_serializer #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
      .CLK(CLK), .RST(RST), .D(D), .LD(LD), .BUSY(BUSY), .TXD(TXD), .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int passed = 0;
   bit chk_on = 1'b0;

   function automatic void chk(string name, int act, int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endfunction

   // Reference model: a frame is just a word and a cycle position within it.
   bit         m_act = 1'b0;
   int         m_t   = 0;
   logic [W-1:0] m_w = '0;

   always @(posedge CLK) begin
      if (!RST) m_act <= 1'b0;
      else if (!m_act) begin
         if (LD) begin
            m_act <= 1'b1;
            m_t   <= 0;
            m_w   <= D;
         end
      end else begin
         m_t   <= m_t + 1;
         m_act <= (m_t + 1 != FL);
      end
   end

   function automatic int exp_txd();
      int b;
      if (!m_act) return 1;
      b = m_t / CPB;
      if (b == 0) return 0;
      if (b <= W) return int'(m_w[b-1]);
      if (PAR == 1 && b == W + 1) return int'(^m_w);
      return 1;
   endfunction

   always @(negedge CLK) begin
      if (chk_on) begin
         chk("model_txd",  int'(TXD),  exp_txd());
         chk("model_busy", int'(BUSY), int'(m_act));
         chk("model_done", int'(DONE), int'(m_act && m_t == FL - 1));
      end
   end

   logic cap_t [0:127];
   logic cap_b [0:127];
   logic cap_d [0:127];

   // Loads d, then samples n cycles; optionally pulses LD with inj_d at sample index inj_at.
   task automatic capture(input logic [W-1:0] d, input int n, input int inj_at,
                          input logic [W-1:0] inj_d);
      @(negedge CLK);
      D  = d;
      LD = 1'b1;
      for (int k = 0; k < n; k++) begin
         @(negedge CLK);
         cap_t[k] = TXD;
         cap_b[k] = BUSY;
         cap_d[k] = DONE;
         if (k == inj_at) begin
            D  = inj_d;
            LD = 1'b1;
         end else begin
            LD = 1'b0;
         end
      end
   endtask

   task automatic check_bits(string name, int base, string pat);
      for (int k = 0; k < pat.len() * CPB; k++)
         chk(name, int'(cap_t[base + k]), (pat[k / CPB] == "1") ? 1 : 0);
   endtask

   task automatic check_frame_shape(string name, int base);
      int nb, nd, di;
      nb = 0; nd = 0; di = -1;
      for (int k = 0; k < FL + 4; k++) begin
         if (cap_b[base + k]) nb++;
         if (cap_d[base + k]) begin nd++; di = k; end
      end
      chk({name, "_busy_cycles"}, nb, FL);
      chk({name, "_done_count"}, nd, 1);
      chk({name, "_done_index"}, di, FL - 1);
   endtask

   string p1011, pf, p5, pa, p6;

   initial begin
`ifdef NIBBLE_SERIALIZER_PARITY_EN
      p1011 = "0110111"; pf = "0111101"; p5 = "0101001"; pa = "0010101"; p6 = "0011001";
`else
      p1011 = "011011";  pf = "011111";  p5 = "010101";  pa = "001011";  p6 = "001101";
`endif
      // Reset / idle
      @(posedge CLK);
      #1 chk_on = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      chk("rst_txd", int'(TXD), 1);
      chk("rst_busy", int'(BUSY), 0);
      chk("rst_done", int'(DONE), 0);
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         chk("idle_txd", int'(TXD), 1);
         chk("idle_busy", int'(BUSY), 0);
      end

      // Single frame
      capture(4'b1011, FL + 4, -1, '0);
      check_bits("frame_1011", 0, p1011);
      check_frame_shape("frame_1011", 0);
      repeat (3) @(negedge CLK);

      // Ignored load mid-frame
      capture(4'hF, FL + 8, 9, 4'h0);
      check_bits("ignored_ld", 0, pf);
      check_frame_shape("ignored_ld", 0);
      for (int k = FL; k < FL + 8; k++) chk("no_second_frame", int'(cap_b[k]), 0);

      // Back-to-back with LD held high
      @(negedge CLK);
      D  = 4'h5;
      LD = 1'b1;
      for (int k = 0; k <= 2 * FL; k++) begin
         @(negedge CLK);
         cap_t[k] = TXD;
         cap_b[k] = BUSY;
         cap_d[k] = DONE;
         if (k == 0) D = 4'hA;
      end
      LD = 1'b0;
      check_bits("b2b_first", 0, p5);
      chk("b2b_gap_txd", int'(cap_t[FL]), 1);
      chk("b2b_gap_busy", int'(cap_b[FL]), 0);
      chk("b2b_second_busy", int'(cap_b[FL + 1]), 1);
      check_bits("b2b_second", FL + 1, pa);
      repeat (4) @(negedge CLK);
      chk("b2b_no_third", int'(BUSY), 0);

      // Reset mid-frame
      capture(4'h9, 11, -1, '0);
      RST = 1'b0;
      @(negedge CLK);
      chk("midrst_txd", int'(TXD), 1);
      chk("midrst_busy", int'(BUSY), 0);
      chk("midrst_done", int'(DONE), 0);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      capture(4'h6, FL + 4, -1, '0);
      check_bits("after_rst", 0, p6);
      check_frame_shape("after_rst", 0);

`ifdef NIBBLE_SERIALIZER_PARITY_EN
      capture(4'b0111, FL + 4, -1, '0);
      check_bits("parity_0111", 0, "0111011");
      chk("parity_frame_len", FL, 28);
      capture(4'b0011, FL + 4, -1, '0);
      check_bits("parity_0011", 0, "0110001");
`endif

      // Randomized traffic, checked by the model every cycle
      repeat (600) begin
         @(negedge CLK);
         RST = ($urandom_range(0, 79) != 0);
         LD  = ($urandom_range(0, 3) == 0);
         D   = W'($urandom);
      end
      @(negedge CLK);
      RST = 1'b1;
      LD  = 1'b0;
      repeat (FL + 2) @(negedge CLK);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
